// File: rtl/comparador_pkg.sv
// Shared types and constants for the nibble-serial magnitude comparator.
package comparador_pkg;

    localparam int DIGITO = 4;

    typedef enum logic {
        OCIOSO,
        COMPARA
    } estado_t;

    typedef struct packed {
        logic maior;
        logic menor;
        logic igual;
    } resultado_t;

    // Final verdict when every nibble matched: the cascade inputs decide.
    function automatic resultado_t resolve_cascata(input resultado_t c);
        resultado_t r;
        r = '0;
        if (c.igual) begin
            r.igual = 1'b1;
        end else if (c.maior && !c.menor) begin
            r.maior = 1'b1;
        end else if (c.menor && !c.maior) begin
            r.menor = 1'b1;
        end else if (!c.maior && !c.menor) begin
            r.maior = 1'b1;
            r.menor = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/comparador_digito.sv
// Combinational 4-bit unsigned magnitude compare of one nibble pair.
module comparador_digito
    import comparador_pkg::*;
(
    input  logic [DIGITO-1:0] a,
    input  logic [DIGITO-1:0] b,
    output logic              maior,
    output logic              menor,
    output logic              igual
);

    assign maior = (a > b);
    assign menor = (a < b);
    assign igual = (a == b);

endmodule

// File: rtl/comparador_sequencial.sv
// Sequential comparator: walks the operands one nibble per clock, MSB first,
// stopping on the first difference and falling back to the cascade inputs.
module comparador_sequencial
    import comparador_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int SIGNED_EN = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iniciar,
    input  logic             sinal,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             entrada_A_maior_B,
    input  logic             entrada_A_menor_B,
    input  logic             entrada_A_igual_B,
    output logic             ocupado,
    output logic             pronto,
    output logic             A_maior_que_B,
    output logic             A_menor_que_B,
    output logic             A_igual_a_B
);

    localparam int NIBBLES = WIDTH / DIGITO;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(NIBBLES - 1);

    estado_t          estado;
    logic [IDX_W-1:0] indice;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sinal_r;
    resultado_t       cascata_r;
    resultado_t       resultado_r;

    logic [DIGITO-1:0] dig_a;
    logic [DIGITO-1:0] dig_b;
    logic              d_maior;
    logic              d_menor;
    logic              d_igual;

    // Flipping the sign bit of the top nibble turns a two's-complement
    // compare into an unsigned one.
    always_comb begin
        dig_a = a_r[DIGITO*int'(indice) +: DIGITO];
        dig_b = b_r[DIGITO*int'(indice) +: DIGITO];
        if (sinal_r && (indice == ULTIMO)) begin
            dig_a[DIGITO-1] = ~dig_a[DIGITO-1];
            dig_b[DIGITO-1] = ~dig_b[DIGITO-1];
        end
    end

    comparador_digito u_digito (
        .a     (dig_a),
        .b     (dig_b),
        .maior (d_maior),
        .menor (d_menor),
        .igual (d_igual)
    );

    // NOTE: all state updates use non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado      <= OCIOSO;
            indice      <= '0;
            a_r         <= '0;
            b_r         <= '0;
            sinal_r     <= 1'b0;
            cascata_r   <= '0;
            resultado_r <= '0;
            ocupado     <= 1'b0;
            pronto      <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    pronto <= 1'b0;
                    if (iniciar) begin
                        a_r       <= A;
                        b_r       <= B;
                        sinal_r   <= (SIGNED_EN != 0) && sinal;
                        cascata_r <= {entrada_A_maior_B, entrada_A_menor_B, entrada_A_igual_B};
                        indice    <= ULTIMO;
                        ocupado   <= 1'b1;
                        estado    <= COMPARA;
                    end
                end
                COMPARA: begin
                    if (!d_igual || (indice == '0)) begin
                        resultado_r <= d_igual ? resolve_cascata(cascata_r)
                                               : resultado_t'{maior: d_maior, menor: d_menor, igual: 1'b0};
                        pronto      <= 1'b1;
                        ocupado     <= 1'b0;
                        estado      <= OCIOSO;
                    end else begin
                        indice <= indice - 1'b1;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    assign A_maior_que_B = resultado_r.maior;
    assign A_menor_que_B = resultado_r.menor;
    assign A_igual_a_B   = resultado_r.igual;

endmodule

// File: tb/tb_comparador_sequencial.sv
// Directed bench for comparador_sequencial (WIDTH=16, signed mode enabled).
module tb_comparador_sequencial;

    logic        clock;
    logic        reset;
    logic        iniciar;
    logic        sinal;
    logic [15:0] A;
    logic [15:0] B;
    logic        entrada_A_maior_B;
    logic        entrada_A_menor_B;
    logic        entrada_A_igual_B;
    logic        ocupado;
    logic        pronto;
    logic        A_maior_que_B;
    logic        A_menor_que_B;
    logic        A_igual_a_B;

    int checks   = 0;
    int failures = 0;

    comparador_sequencial #(.WIDTH(16), .SIGNED_EN(1)) dut (
        .clock             (clock),
        .reset             (reset),
        .iniciar           (iniciar),
        .sinal             (sinal),
        .A                 (A),
        .B                 (B),
        .entrada_A_maior_B (entrada_A_maior_B),
        .entrada_A_menor_B (entrada_A_menor_B),
        .entrada_A_igual_B (entrada_A_igual_B),
        .ocupado           (ocupado),
        .pronto            (pronto),
        .A_maior_que_B     (A_maior_que_B),
        .A_menor_que_B     (A_menor_que_B),
        .A_igual_a_B       (A_igual_a_B)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [2:0]  casc;  // {maior, menor, igual}
        int          lat;
        logic [2:0]  res;   // {A_maior, A_menor, A_igual}
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] res_now();
        return {A_maior_que_B, A_menor_que_B, A_igual_a_B};
    endfunction

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [2:0] casc);
        A = a;
        B = b;
        sinal = s;
        {entrada_A_maior_B, entrada_A_menor_B, entrada_A_igual_B} = casc;
        iniciar = 1'b1;
    endtask

    // Called right after iniciar was raised at a falling edge; counts falling
    // edges until pronto is seen. lat=0 means the bound expired.
    task automatic wait_pronto(input int max_cycles, output int lat, output logic first_ocup);
        lat = 0;
        first_ocup = 1'b0;
        for (int i = 1; i <= max_cycles; i++) begin
            @(negedge clock);
            iniciar = 1'b0;
            if (i == 1) first_ocup = ocupado;
            if (pronto) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic run_vec(input int idx);
        int   lat;
        logic fo;
        @(negedge clock);
        drive(vecs[idx].a, vecs[idx].b, vecs[idx].s, vecs[idx].casc);
        wait_pronto(10, lat, fo);
        check($sformatf("v%0d latency", idx), lat, vecs[idx].lat);
        check($sformatf("v%0d ocupado_after_start", idx), fo, 1);
        check($sformatf("v%0d result", idx), res_now(), vecs[idx].res);
        check($sformatf("v%0d ocupado_on_pronto", idx), ocupado, 0);
        @(negedge clock);
        check($sformatf("v%0d pronto_one_cycle", idx), pronto, 0);
        check($sformatf("v%0d result_held", idx), res_now(), vecs[idx].res);
    endtask

    initial begin
        int   lat;
        logic fo;
        logic seen;

        vecs[0]  = '{16'h8000, 16'h7FFF, 1'b0, 3'b000, 2, 3'b100};
        vecs[1]  = '{16'h8000, 16'h7FFF, 1'b1, 3'b000, 2, 3'b010};
        vecs[2]  = '{16'h1234, 16'h1234, 1'b0, 3'b001, 5, 3'b001};
        vecs[3]  = '{16'h1234, 16'h1234, 1'b0, 3'b100, 5, 3'b100};
        vecs[4]  = '{16'h1234, 16'h1234, 1'b0, 3'b000, 5, 3'b110};
        vecs[5]  = '{16'h1234, 16'h1234, 1'b0, 3'b110, 5, 3'b000};
        vecs[6]  = '{16'h1235, 16'h1234, 1'b0, 3'b000, 5, 3'b100};
        vecs[7]  = '{16'h1224, 16'h1234, 1'b0, 3'b100, 4, 3'b010};
        vecs[8]  = '{16'hFFFF, 16'h0001, 1'b1, 3'b000, 2, 3'b010};
        vecs[9]  = '{16'h7FFF, 16'h7FFE, 1'b1, 3'b001, 5, 3'b100};
        vecs[10] = '{16'hFFFF, 16'h0001, 1'b0, 3'b000, 2, 3'b100};
        vecs[11] = '{16'h8000, 16'h8001, 1'b1, 3'b001, 5, 3'b010};

        reset = 1'b1;
        iniciar = 1'b0;
        sinal = 1'b0;
        A = '0;
        B = '0;
        entrada_A_maior_B = 1'b0;
        entrada_A_menor_B = 1'b0;
        entrada_A_igual_B = 1'b0;
        repeat (2) @(negedge clock);
        check("reset ocupado", ocupado, 0);
        check("reset pronto", pronto, 0);
        check("reset result", res_now(), 3'b000);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i);

        // Second iniciar during COMPARA must not disturb the running compare.
        @(negedge clock);
        drive(16'h1235, 16'h1234, 1'b0, 3'b000);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 2) drive(16'h0000, 16'hFFFF, 1'b1, 3'b001);
            else iniciar = 1'b0;
            if (pronto) begin
                lat = i;
                break;
            end
        end
        check("ignore latency", lat, 5);
        check("ignore result", res_now(), 3'b100);
        repeat (2) @(negedge clock);
        check("ignore no_restart", ocupado, 0);

        // Reset two cycles into a full-length compare aborts it.
        @(negedge clock);
        drive(16'h1234, 16'h1234, 1'b0, 3'b001);
        @(negedge clock);
        iniciar = 1'b0;
        @(negedge clock);
        check("abort ocupado_before", ocupado, 1);
        reset = 1'b1;
        #1;
        check("abort ocupado", ocupado, 0);
        check("abort pronto", pronto, 0);
        check("abort result", res_now(), 3'b000);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (pronto || ocupado) seen = 1'b1;
        end
        check("abort no_pronto", seen, 0);
        check("abort result_after", res_now(), 3'b000);
        @(negedge clock);
        drive(16'h8000, 16'h7FFF, 1'b0, 3'b000);
        wait_pronto(10, lat, fo);
        check("fresh latency", lat, 2);
        check("fresh result", res_now(), 3'b100);

        // Back-to-back: iniciar raised during the pronto cycle.
        @(negedge clock);
        drive(16'h1235, 16'h1234, 1'b0, 3'b000);
        wait_pronto(10, lat, fo);
        check("b2b first latency", lat, 5);
        check("b2b first result", res_now(), 3'b100);
        drive(16'h8000, 16'h7FFF, 1'b1, 3'b000);
        wait_pronto(10, lat, fo);
        check("b2b no_gap ocupado", fo, 1);
        check("b2b second latency", lat, 2);
        check("b2b second result", res_now(), 3'b010);
        @(negedge clock);
        check("b2b pronto_one_cycle", pronto, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
